// File: rtl/adder_tree_scheduler_if.sv
// Command, bank-read, tree-sum and result signals of adder_tree_scheduler.
interface adder_tree_scheduler_if #(
  parameter int ADDR_W = 6,
  parameter int PASS_W = 8,
  parameter int ACC_W  = 20
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [PASS_W-1:0] cmd_passes;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       tree_sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_ovf;
  logic              busy;

  modport master (
    output cmd_valid, cmd_base, cmd_passes, tree_sum, res_ready,
    input  cmd_ready, rd_en, rd_addr, res_valid, res_data, res_ovf, busy
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_passes, tree_sum, res_ready,
    output cmd_ready, rd_en, rd_addr, res_valid, res_data, res_ovf, busy
  );
endinterface

// File: rtl/adder_tree_scheduler.sv
// Issues one bank-row read per cycle for a reduction command and accumulates the adder-tree sums.
// Optional macro ADDER_TREE_SAT_EN: accumulator saturates on overflow instead of wrapping.
module adder_tree_scheduler #(
  parameter int ADDR_W   = 6,
  parameter int PASS_W   = 8,
  parameter int ACC_W    = 20,
  parameter int TREE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_tree_scheduler_if.slave io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [PASS_W-1:0]   r_cnt;
  logic [TREE_LAT-1:0] r_tag;
  logic [TREE_LAT-1:0] w_tag_shift;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;
  logic                w_cmd_ready;
  logic                w_rd_en;
  logic                w_res_valid;
  logic                w_accept;
  logic [ACC_W:0]      w_sum;

  // Tag pipeline shifted by one stage, without the new read entering at the head.
  generate
    for (genvar gi = 0; gi < TREE_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign w_tag_shift[gi] = 1'b0;
      end else begin : g_body
        assign w_tag_shift[gi] = r_tag[gi-1];
      end
    end
  endgenerate

  assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - 12){1'b0}}, io_bus.tree_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_rd_en      = 1'b0;
    w_res_valid  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = ~rst;
        if (io_bus.cmd_valid && w_cmd_ready) begin
          w_accept     = 1'b1;
          w_state_next = (io_bus.cmd_passes == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rd_en = 1'b1;
        if (r_cnt == PASS_W'(1)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Only the final stage may still hold a tag; its add lands on this edge.
        if (w_tag_shift == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        if (io_bus.res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_tag  <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_tag <= w_tag_shift | TREE_LAT'(w_rd_en);
      if (w_accept) begin
        r_addr <= io_bus.cmd_base;
        r_cnt  <= io_bus.cmd_passes;
        r_acc  <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_rd_en) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - PASS_W'(1);
        end
        if (r_tag[TREE_LAT-1]) begin
          r_ovf <= r_ovf | w_sum[ACC_W];
`ifdef ADDER_TREE_SAT_EN
          r_acc <= (w_sum[ACC_W] || r_ovf) ? '1 : w_sum[ACC_W-1:0];
`else
          r_acc <= w_sum[ACC_W-1:0];
`endif
        end
      end
    end
  end

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.rd_en     = w_rd_en;
  assign io_bus.rd_addr   = r_addr;
  assign io_bus.res_valid = w_res_valid;
  assign io_bus.res_data  = r_acc;
  assign io_bus.res_ovf   = r_ovf;
  assign io_bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Self-checking bench for adder_tree_scheduler: bank/tree model plus arithmetic reference sum.
module tb_adder_tree_scheduler;
  localparam int ADDR_W   = 6;
  localparam int PASS_W   = 8;
  localparam int ACC_W    = 12;
  localparam int TREE_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_tree_scheduler_if #(.ADDR_W(ADDR_W), .PASS_W(PASS_W), .ACC_W(ACC_W)) bus_if ();

  adder_tree_scheduler #(
    .ADDR_W(ADDR_W), .PASS_W(PASS_W), .ACC_W(ACC_W), .TREE_LAT(TREE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus_if)
  );

  // Bank array (1 registered read) followed by the tree output register; garbage when idle.
  logic [11:0] mem [64];
  logic [11:0] sram_q;
  always @(posedge clk) begin
    sram_q          <= bus_if.rd_en ? mem[bus_if.rd_addr] : 12'($urandom);
    bus_if.tree_sum <= sram_q;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int base, input int n, output int acc, output bit ovf);
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += int'(mem[(base + i) % 64]);
      if (acc >= (1 << ACC_W)) begin
        ovf = 1'b1;
`ifdef ADDER_TREE_SAT_EN
        acc = (1 << ACC_W) - 1;
`else
        acc -= (1 << ACC_W);
`endif
      end
    end
  endfunction

  task automatic do_cmd(input string tag, input int base, input int n, input int hold);
    int exp_acc;
    bit exp_ovf;
    logic [ACC_W-1:0] held;
    model(base, n, exp_acc, exp_ovf);
    @(negedge clk);
    check({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 1);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_base   = ADDR_W'(base);
    bus_if.cmd_passes = PASS_W'(n);
    @(negedge clk);
    // Junk command and res_ready during the run must be ignored.
    bus_if.cmd_base   = ADDR_W'($urandom);
    bus_if.cmd_passes = PASS_W'($urandom);
    for (int k = 1; k <= n; k++) begin
      check({tag, "_rd_en"}, 32'(bus_if.rd_en), 1);
      check({tag, "_rd_addr"}, 32'(bus_if.rd_addr), 32'((base + k - 1) % 64));
      check({tag, "_busy"}, 32'(bus_if.busy), 1);
      bus_if.res_ready = 1'($urandom);
      @(negedge clk);
    end
    if (n > 0) begin
      for (int j = 0; j < TREE_LAT; j++) begin
        check({tag, "_drain_rd_en"}, 32'(bus_if.rd_en), 0);
        check({tag, "_early_valid"}, 32'(bus_if.res_valid), 0);
        bus_if.res_ready = 1'($urandom);
        @(negedge clk);
      end
    end
    bus_if.res_ready = 1'b0;
    check({tag, "_res_valid"}, 32'(bus_if.res_valid), 1);
    check({tag, "_res_data"}, 32'(bus_if.res_data), 32'(exp_acc));
    check({tag, "_res_ovf"}, 32'(bus_if.res_ovf), 32'(exp_ovf));
    check({tag, "_done_rd_en"}, 32'(bus_if.rd_en), 0);
    held = bus_if.res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus_if.res_valid), 1);
      check({tag, "_hold_data"}, 32'(bus_if.res_data), 32'(held));
      check({tag, "_hold_ovf"}, 32'(bus_if.res_ovf), 32'(exp_ovf));
      check({tag, "_hold_cmd_ready"}, 32'(bus_if.cmd_ready), 0);
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    bus_if.res_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(bus_if.res_valid), 0);
    check({tag, "_post_cmd_ready"}, 32'(bus_if.cmd_ready), 1);
    check({tag, "_post_busy"}, 32'(bus_if.busy), 0);
    $display("[TB] %s base=%0d passes=%0d hold=%0d exp_data=%0d exp_ovf=%0d", tag, base, n, hold,
             exp_acc, exp_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 0);
    check({tag, "_rd_en"}, 32'(bus_if.rd_en), 0);
    check({tag, "_rd_addr"}, 32'(bus_if.rd_addr), 0);
    check({tag, "_res_valid"}, 32'(bus_if.res_valid), 0);
    check({tag, "_res_data"}, 32'(bus_if.res_data), 0);
    check({tag, "_res_ovf"}, 32'(bus_if.res_ovf), 0);
    check({tag, "_busy"}, 32'(bus_if.busy), 0);
  endtask

  initial begin
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_base   = '0;
    bus_if.cmd_passes = '0;
    bus_if.res_ready  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    rst = 1'b0;
    @(negedge clk);
    check("reset_release_cmd_ready", 32'(bus_if.cmd_ready), 1);
    check("reset_release_busy", 32'(bus_if.busy), 0);
    $display("[TB] reset sequence done");

    // Basic reduction.
    mem[5] = 12'd100; mem[6] = 12'd200; mem[7] = 12'd300; mem[8] = 12'd400;
    do_cmd("basic", 5, 4, 0);

    // Address wrap with result back-pressure.
    do_cmd("wrap", 62, 4, 5);

    // Zero passes.
    do_cmd("zero", 17, 0, 2);

    // Overflow.
    mem[20] = 12'd4080; mem[21] = 12'd4080;
    do_cmd("ovf", 20, 2, 1);

    // Mid-command reset during the third read of an eight-pass command.
    @(negedge clk);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_base   = ADDR_W'(30);
    bus_if.cmd_passes = PASS_W'(8);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_third_read", 32'(bus_if.rd_en), 1);
    rst = 1'b1;
    #1;
    check("midrst_rd_en_async", 32'(bus_if.rd_en), 0);
    check("midrst_busy_async", 32'(bus_if.busy), 0);
    check("midrst_cmd_ready", 32'(bus_if.cmd_ready), 0);
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("midrst_hold");
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(bus_if.res_valid), 0);
      check("midrst_no_rd", 32'(bus_if.rd_en), 0);
      check("midrst_idle_ready", 32'(bus_if.cmd_ready), 1);
    end
    $display("[TB] mid-command reset done");
    mem[40] = 12'd1234;
    do_cmd("after_rst", 40, 1, 0);

    // Randomized commands.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 12'($urandom);
      do_cmd("rand", int'($urandom_range(0, 63)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
